// File: rtl/wb_port_arbiter_pkg.sv
// wb_port_arbiter_pkg
//   Shared types and constants for the writeback-port arbiter slice:
//   exception payload, per-port writeback bundle, port/id sizing and a
//   helper for index widths.
package wb_port_arbiter_pkg;

  localparam int unsigned NR_WB_PORTS   = 3;
  localparam int unsigned TRANS_ID_BITS = 2;
  localparam int unsigned XLEN          = 64;

  localparam logic [XLEN-1:0] ILLEGAL_INSTR = 64'h2;

  typedef struct packed {
    logic [XLEN-1:0] cause;
    logic [XLEN-1:0] tval;
    logic            valid;
  } exception_t;

  // One functional unit's writeback payload.
  typedef struct packed {
    logic [TRANS_ID_BITS-1:0] trans_id;
    logic [XLEN-1:0]          data;
    exception_t               ex;
  } wb_req_t;

  // Width needed to index n items (at least one bit).
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arb_onehot.sv
// rr_arb_onehot
//   Purely combinational masked round-robin picker. Searches req starting
//   at position ptr and wrapping modulo N; the first set bit wins.
//   Ports:
//     req  in  N    request vector
//     ptr  in  IW   search start position (0..N-1)
//     gnt  out N    one-hot grant (zero when no request)
//     idx  out IW   index of the granted bit (0 when no request)
//     any  out 1    at least one request present
module rr_arb_onehot
  import wb_port_arbiter_pkg::*;
#(
  parameter int unsigned N = NR_WB_PORTS
) (
  input  logic [N-1:0]            req,
  input  logic [idx_width(N)-1:0] ptr,
  output logic [N-1:0]            gnt,
  output logic [idx_width(N)-1:0] idx,
  output logic                    any
);

  localparam int unsigned IW = idx_width(N);

  logic [N-1:0] mask;
  logic [N-1:0] masked;
  logic [N-1:0] src;

  // Requests at or above ptr take precedence; if none, fall back to the
  // unmasked vector, which realises the wrap-around.
  always_comb begin
    mask   = '0;
    masked = '0;
    src    = '0;
    idx    = '0;
    any    = |req;
    for (int i = 0; i < int'(N); i++) begin
      mask[i] = (i >= int'(ptr));
    end
    masked = req & mask;
    src    = (|masked) ? masked : req;
    // Descending scan so the lowest set bit is the last assignment.
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (src[i]) begin
        idx = IW'(i);
      end
    end
    gnt = any ? (N'(1) << idx) : '0;
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
//   Shares the single scoreboard writeback port between NR_PORTS
//   functional-unit result streams. Round-robin arbitration into a
//   one-entry registered output slot with valid/ready on both sides.
//   flush_i drops the buffered result and swallows all requests.
//   Optional: define WB_ARB_EX_PRIO_EN to let requests carrying an
//   exception win over plain requests (round-robin within each class).
//   Ports:
//     clk_i          in   clock, rising edge
//     rst_i          in   synchronous active-high reset
//     flush_i        in   discard slot, accept-and-drop all requests
//     wb_valid_i     in   per-port result valid
//     wb_trans_id_i  in   per-port scoreboard id
//     wb_data_i      in   per-port result
//     wb_ex_i        in   per-port exception
//     wb_ready_o     out  per-port accept (combinational)
//     sb_valid_o     out  output result valid
//     sb_trans_id_o  out  output id
//     sb_data_o      out  output result
//     sb_ex_o        out  output exception
//     sb_ready_i     in   scoreboard accepts output
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int unsigned NR_PORTS = NR_WB_PORTS,
  parameter int unsigned ID_W     = TRANS_ID_BITS
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               flush_i,
  input  logic [NR_PORTS-1:0]                wb_valid_i,
  input  logic [NR_PORTS-1:0][ID_W-1:0]      wb_trans_id_i,
  input  logic [NR_PORTS-1:0][XLEN-1:0]      wb_data_i,
  input  exception_t [NR_PORTS-1:0]          wb_ex_i,
  output logic [NR_PORTS-1:0]                wb_ready_o,
  output logic                               sb_valid_o,
  output logic [ID_W-1:0]                    sb_trans_id_o,
  output logic [XLEN-1:0]                    sb_data_o,
  output exception_t                         sb_ex_o,
  input  logic                               sb_ready_i
);

  localparam int unsigned IW = idx_width(NR_PORTS);

  // Output slot and round-robin pointer
  logic             valid_q;
  logic [ID_W-1:0]  trans_id_q;
  logic [XLEN-1:0]  data_q;
  exception_t       ex_q;
  logic [IW-1:0]    rr_q;

  logic                slot_free_c;
  logic [NR_PORTS-1:0] all_gnt_c;
  logic [IW-1:0]       all_idx_c;
  logic                all_any_c;
  logic [NR_PORTS-1:0] win_gnt_c;
  logic [IW-1:0]       win_idx_c;
  logic                win_any_c;
  logic [IW-1:0]       rr_next_c;

  // Slot can accept when empty or being drained this cycle.
  assign slot_free_c = !valid_q || sb_ready_i;

  // Plain round-robin over all requesters.
  rr_arb_onehot #(
    .N (NR_PORTS)
  ) u_rr_all (
    .req (wb_valid_i),
    .ptr (rr_q),
    .gnt (all_gnt_c),
    .idx (all_idx_c),
    .any (all_any_c)
  );

`ifdef WB_ARB_EX_PRIO_EN
  logic [NR_PORTS-1:0] ex_req_c;
  logic [NR_PORTS-1:0] ex_gnt_c;
  logic [IW-1:0]       ex_idx_c;
  logic                ex_any_c;

  // Requests carrying an exception form the high-priority class.
  always_comb begin
    ex_req_c = '0;
    for (int k = 0; k < int'(NR_PORTS); k++) begin
      ex_req_c[k] = wb_valid_i[k] && wb_ex_i[k].valid;
    end
  end

  rr_arb_onehot #(
    .N (NR_PORTS)
  ) u_rr_ex (
    .req (ex_req_c),
    .ptr (rr_q),
    .gnt (ex_gnt_c),
    .idx (ex_idx_c),
    .any (ex_any_c)
  );

  assign win_gnt_c = ex_any_c ? ex_gnt_c : all_gnt_c;
  assign win_idx_c = ex_any_c ? ex_idx_c : all_idx_c;
  assign win_any_c = all_any_c;
`else
  assign win_gnt_c = all_gnt_c;
  assign win_idx_c = all_idx_c;
  assign win_any_c = all_any_c;
`endif

  // Pointer moves to the port after the winner, wrapping to 0.
  assign rr_next_c = (win_idx_c == IW'(NR_PORTS - 1)) ? '0 : win_idx_c + IW'(1);

  // Accept: nothing in reset, everything on flush, else the winner when
  // the slot can take it.
  always_comb begin
    wb_ready_o = '0;
    if (rst_i) begin
      wb_ready_o = '0;
    end else if (flush_i) begin
      wb_ready_o = '1;
    end else if (slot_free_c) begin
      wb_ready_o = win_gnt_c;
    end
  end

  // Slot and pointer update.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q    <= 1'b0;
      trans_id_q <= '0;
      data_q     <= '0;
      ex_q       <= '0;
      rr_q       <= '0;
    end else if (flush_i) begin
      valid_q <= 1'b0;
    end else if (slot_free_c) begin
      valid_q <= win_any_c;
      if (win_any_c) begin
        trans_id_q <= wb_trans_id_i[win_idx_c];
        data_q     <= wb_data_i[win_idx_c];
        ex_q       <= wb_ex_i[win_idx_c];
        rr_q       <= rr_next_c;
      end
    end
  end

  assign sb_valid_o    = valid_q;
  assign sb_trans_id_o = trans_id_q;
  assign sb_data_o     = data_q;
  assign sb_ex_o       = ex_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter
//   Directed table-driven bench for wb_port_arbiter plus hand-written
//   sequences for reset, exception priority and mid-run reset.
module tb_wb_port_arbiter;
  import wb_port_arbiter_pkg::*;

  localparam int unsigned NP  = NR_WB_PORTS;
  localparam int unsigned IDW = TRANS_ID_BITS;

  logic                          clk;
  logic                          rst;
  logic                          flush;
  logic [NP-1:0]                 wb_valid;
  logic [NP-1:0][IDW-1:0]        wb_trans_id;
  logic [NP-1:0][XLEN-1:0]       wb_data;
  exception_t [NP-1:0]           wb_ex;
  logic [NP-1:0]                 wb_ready;
  logic                          sb_valid;
  logic [IDW-1:0]                sb_trans_id;
  logic [XLEN-1:0]               sb_data;
  exception_t                    sb_ex;
  logic                          sb_ready;

  wb_port_arbiter #(
    .NR_PORTS (NP),
    .ID_W     (IDW)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .flush_i       (flush),
    .wb_valid_i    (wb_valid),
    .wb_trans_id_i (wb_trans_id),
    .wb_data_i     (wb_data),
    .wb_ex_i       (wb_ex),
    .wb_ready_o    (wb_ready),
    .sb_valid_o    (sb_valid),
    .sb_trans_id_o (sb_trans_id),
    .sb_data_o     (sb_data),
    .sb_ex_o       (sb_ex),
    .sb_ready_i    (sb_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  valid;
    logic        fl;
    logic        rdy;
    logic [2:0]  exp_ready;
    logic        exp_valid;
    logic [1:0]  exp_id;
    logic [63:0] exp_data;
    logic [1:0]  exp_rr;
  } vec_t;

  localparam int NV = 18;
  vec_t    vecs [NV];
  wb_req_t port_req [NP];

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [2:0] v, input logic fl, input logic rdy,
                              input logic [2:0] er, input logic ev, input logic [1:0] eid,
                              input logic [63:0] ed, input logic [1:0] err);
    vec_t r;
    r.valid = v; r.fl = fl; r.rdy = rdy; r.exp_ready = er;
    r.exp_valid = ev; r.exp_id = eid; r.exp_data = ed; r.exp_rr = err;
    return r;
  endfunction

  task automatic load_ports();
    for (int k = 0; k < int'(NP); k++) begin
      wb_trans_id[k] = port_req[k].trans_id;
      wb_data[k]     = port_req[k].data;
      wb_ex[k]       = port_req[k].ex;
    end
  endtask

  task automatic drive(input logic [2:0] v, input logic fl, input logic rdy);
    wb_valid = v;
    flush    = fl;
    sb_ready = rdy;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    port_req[0] = '{trans_id: 2'd1, data: 64'hA0,   ex: '0};
    port_req[1] = '{trans_id: 2'd2, data: 64'hDEAD, ex: '0};
    port_req[2] = '{trans_id: 2'd3, data: 64'hC2,   ex: '0};

    // valid fl rdy | ready sbv id data rr   (sb_*/rr are pre-edge state)
    vecs[0]  = mk(3'b010, 0, 1, 3'b010, 0, 2'd0, 64'h0,    2'd0);
    vecs[1]  = mk(3'b000, 0, 1, 3'b000, 1, 2'd2, 64'hDEAD, 2'd2);
    vecs[2]  = mk(3'b111, 0, 1, 3'b100, 0, 2'd0, 64'h0,    2'd2);
    vecs[3]  = mk(3'b111, 0, 1, 3'b001, 1, 2'd3, 64'hC2,   2'd0);
    vecs[4]  = mk(3'b111, 0, 1, 3'b010, 1, 2'd1, 64'hA0,   2'd1);
    vecs[5]  = mk(3'b111, 0, 1, 3'b100, 1, 2'd2, 64'hDEAD, 2'd2);
    vecs[6]  = mk(3'b111, 0, 0, 3'b000, 1, 2'd3, 64'hC2,   2'd0);
    vecs[7]  = mk(3'b111, 0, 0, 3'b000, 1, 2'd3, 64'hC2,   2'd0);
    vecs[8]  = mk(3'b100, 0, 0, 3'b000, 1, 2'd3, 64'hC2,   2'd0);
    vecs[9]  = mk(3'b100, 0, 1, 3'b100, 1, 2'd3, 64'hC2,   2'd0);
    vecs[10] = mk(3'b101, 1, 1, 3'b111, 1, 2'd3, 64'hC2,   2'd0);
    vecs[11] = mk(3'b000, 0, 1, 3'b000, 0, 2'd0, 64'h0,    2'd0);
    vecs[12] = mk(3'b010, 0, 1, 3'b010, 0, 2'd0, 64'h0,    2'd0);
    vecs[13] = mk(3'b011, 0, 1, 3'b001, 1, 2'd2, 64'hDEAD, 2'd2);
    vecs[14] = mk(3'b000, 0, 1, 3'b000, 1, 2'd1, 64'hA0,   2'd1);
    vecs[15] = mk(3'b100, 0, 0, 3'b100, 0, 2'd0, 64'h0,    2'd1);
    vecs[16] = mk(3'b001, 1, 0, 3'b111, 1, 2'd3, 64'hC2,   2'd0);
    vecs[17] = mk(3'b000, 0, 0, 3'b000, 0, 2'd0, 64'h0,    2'd0);

    // Reset with every port requesting: nothing may be accepted.
    rst = 1'b1;
    load_ports();
    drive(3'b111, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    #1 chk("reset ready", 64'(wb_ready), 64'h0);
    @(negedge clk);
    rst = 1'b0;
    drive(3'b000, 1'b0, 1'b1);
    #1;
    chk("reset sb_valid", 64'(sb_valid), 64'h0);
    chk("reset sb_id", 64'(sb_trans_id), 64'h0);
    chk("reset sb_data", sb_data, 64'h0);
    chk("reset sb_ex_valid", 64'(sb_ex.valid), 64'h0);
    chk("reset rr", 64'(dut.rr_q), 64'h0);

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].valid, vecs[i].fl, vecs[i].rdy);
      #1;
      chk($sformatf("v%0d ready", i), 64'(wb_ready), 64'(vecs[i].exp_ready));
      chk($sformatf("v%0d sb_valid", i), 64'(sb_valid), 64'(vecs[i].exp_valid));
      chk($sformatf("v%0d rr", i), 64'(dut.rr_q), 64'(vecs[i].exp_rr));
      if (vecs[i].exp_valid) begin
        chk($sformatf("v%0d sb_id", i), 64'(sb_trans_id), 64'(vecs[i].exp_id));
        chk($sformatf("v%0d sb_data", i), sb_data, vecs[i].exp_data);
      end
      @(negedge clk);
    end

    // Exception request on port2 against a plain request on port0, rr=0.
    wb_ex[2] = '{cause: ILLEGAL_INSTR, tval: 64'h0, valid: 1'b1};
    drive(3'b101, 1'b0, 1'b1);
    #1;
`ifdef WB_ARB_EX_PRIO_EN
    chk("ex A ready", 64'(wb_ready), 64'(3'b100));
    @(negedge clk);
    drive(3'b001, 1'b0, 1'b1);
    #1;
    chk("ex B ready", 64'(wb_ready), 64'(3'b001));
    chk("ex B sb_valid", 64'(sb_valid), 64'h1);
    chk("ex B sb_id", 64'(sb_trans_id), 64'h3);
    chk("ex B cause", sb_ex.cause, 64'h2);
    chk("ex B ex_valid", 64'(sb_ex.valid), 64'h1);
    @(negedge clk);
    drive(3'b000, 1'b0, 1'b1);
    #1;
    chk("ex C sb_valid", 64'(sb_valid), 64'h1);
    chk("ex C sb_id", 64'(sb_trans_id), 64'h1);
    chk("ex C ex_valid", 64'(sb_ex.valid), 64'h0);
    chk("ex C rr", 64'(dut.rr_q), 64'h1);
`else
    chk("ex A ready", 64'(wb_ready), 64'(3'b001));
    @(negedge clk);
    drive(3'b100, 1'b0, 1'b1);
    #1;
    chk("ex B ready", 64'(wb_ready), 64'(3'b100));
    chk("ex B sb_valid", 64'(sb_valid), 64'h1);
    chk("ex B sb_id", 64'(sb_trans_id), 64'h1);
    chk("ex B sb_data", sb_data, 64'hA0);
    chk("ex B ex_valid", 64'(sb_ex.valid), 64'h0);
    @(negedge clk);
    drive(3'b000, 1'b0, 1'b1);
    #1;
    chk("ex C sb_valid", 64'(sb_valid), 64'h1);
    chk("ex C sb_id", 64'(sb_trans_id), 64'h3);
    chk("ex C cause", sb_ex.cause, 64'h2);
    chk("ex C ex_valid", 64'(sb_ex.valid), 64'h1);
    chk("ex C rr", 64'(dut.rr_q), 64'h0);
`endif
    @(negedge clk);

    // Mid-run reset overrides flush and requests, then clears the slot.
    rst = 1'b1;
    drive(3'b111, 1'b1, 1'b1);
    #1 chk("midreset ready", 64'(wb_ready), 64'h0);
    @(negedge clk);
    rst = 1'b0;
    drive(3'b000, 1'b0, 1'b1);
    #1;
    chk("midreset sb_valid", 64'(sb_valid), 64'h0);
    chk("midreset sb_id", 64'(sb_trans_id), 64'h0);
    chk("midreset sb_data", sb_data, 64'h0);
    chk("midreset cause", sb_ex.cause, 64'h0);
    chk("midreset rr", 64'(dut.rr_q), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
